// File: rtl/brq_result_checker.sv
// -----------------------------------------------------------------------------
// brq_result_checker
//
// Golden-sequence checker placed downstream of the RV32IM core top. It holds
// a table of expected Reg_Out values that is loaded through a simple write
// port. After a start pulse it watches Reg_Out and steps through the table on
// each in-order match, then settles in PASS, TOUT (no match for TIMEOUT
// cycles) or, in strict builds, FAIL. The status can drive FPGA LEDs directly.
//
// Build option:
//   CHECKER_STRICT_EN - when defined, any observed Reg_Out change that does not
//                       equal the next expected entry ends the run in FAIL and
//                       latches the offending value on fail_value. When it is
//                       undefined, mismatches are ignored, so any ordered
//                       subsequence passes, and fail_value is tied to 0.
//
// Ports:
//   brq_clk      in   core clock
//   brq_rst      in   synchronous active-high reset (table contents survive)
//   exp_we       in   table write enable (ignored while busy)
//   exp_addr     in   table write address
//   exp_wdata    in   table write data
//   exp_count    in   number of valid entries, sampled on start, clamped to DEPTH
//   start        in   single-cycle pulse that begins checking
//   Reg_Out      in   observed core debug output
//   busy         out  checking in progress
//   done         out  run finished (PASS, FAIL or TOUT)
//   pass         out  run finished successfully
//   match_pulse  out  one-cycle pulse per accepted match
//   match_idx    out  number of accepted matches in this run
//   fail_value   out  Reg_Out value that caused FAIL (strict builds only)
// -----------------------------------------------------------------------------
module brq_result_checker #(
  parameter int DataWidth = 32,
  parameter int DEPTH     = 128,
  parameter int TIMEOUT   = 4096,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 exp_we,
  input  logic [IDX_W-1:0]     exp_addr,
  input  logic [DataWidth-1:0] exp_wdata,
  input  logic [IDX_W:0]       exp_count,
  input  logic                 start,
  input  logic [DataWidth-1:0] Reg_Out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 match_pulse,
  output logic [IDX_W:0]       match_idx,
  output logic [DataWidth-1:0] fail_value
);

  // Watchdog only has to count up to TIMEOUT-1.
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ONE    = WD_W'(1);
  localparam logic [WD_W-1:0]  WD_ZERO   = WD_W'(0);
  localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   IDX_ONE   = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]   IDX_ZERO  = (IDX_W + 1)'(0);

`ifdef CHECKER_STRICT_EN
  localparam logic STRICT_EN = 1'b1;
`else
  localparam logic STRICT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TOUT = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DataWidth-1:0]  r_table [DEPTH];
  logic [IDX_W:0]        r_n;
  logic [IDX_W:0]        r_match_idx;
  logic [WD_W-1:0]       r_wdog;
  logic [DataWidth-1:0]  r_prev;
  logic                  r_first_obs;
  logic                  r_match_pulse;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;

  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_pass_nxt;
  logic                  w_in_run;
  logic                  w_seq_done;
  logic                  w_active;
  logic [DataWidth-1:0]  w_exp_val;
  logic                  w_observe;
  logic                  w_table_eq;
  logic                  w_match;
  logic                  w_mismatch;
  logic                  w_wdog_last;
  logic                  w_start_take;
  logic                  w_tab_we;
  logic [IDX_W:0]        w_n_clamped;

  // ---------------------------------------------------------------------------
  // Match detection
  // ---------------------------------------------------------------------------
  assign w_in_run    = (r_state == ST_RUN);
  // Once every entry has matched, the run spends one cycle in RUN before PASS;
  // no comparison happens in that cycle.
  assign w_seq_done  = w_in_run && (r_match_idx == r_n);
  assign w_active    = w_in_run && (r_match_idx != r_n);
  // Combinational read so the comparison always uses the current match_idx.
  assign w_exp_val   = r_table[r_match_idx[IDX_W-1:0]];
  // The first RUN cycle always counts as an observation; after that only a
  // change of Reg_Out does, so a held value can match at most one entry.
  assign w_observe   = w_active && (r_first_obs || (Reg_Out != r_prev));
  assign w_table_eq  = (Reg_Out == w_exp_val);
  assign w_match     = w_observe && w_table_eq;
  assign w_mismatch  = STRICT_EN && w_observe && !w_table_eq;
  assign w_wdog_last = (r_wdog == WD_LAST);

  // start is honoured from IDLE and from every terminal state, never in RUN.
  assign w_start_take = start && ((r_state == ST_IDLE) || (r_state == ST_PASS) ||
                                  (r_state == ST_FAIL) || (r_state == ST_TOUT));
  assign w_tab_we     = exp_we && !w_in_run;
  assign w_n_clamped  = (exp_count > DEPTH_CNT) ? DEPTH_CNT : exp_count;

  // ---------------------------------------------------------------------------
  // Expected-value table (not reset; contents survive brq_rst)
  // ---------------------------------------------------------------------------
  // Table write port; a write in the same cycle as start is visible to the
  // first RUN comparison because the read is combinational.
  always_ff @(posedge brq_clk) begin
    if (w_tab_we) begin
      r_table[exp_addr] <= exp_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; completion beats match, match beats mismatch/timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_seq_done) begin
          w_state_nxt = ST_PASS;
        end else if (w_match) begin
          w_state_nxt = ST_RUN;
        end else if (w_mismatch) begin
          w_state_nxt = ST_FAIL;
        end else if (w_wdog_last) begin
          w_state_nxt = ST_TOUT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL, ST_TOUT: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode of the next state so the registered flags track r_state.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_pass_nxt = 1'b0;
    case (w_state_nxt)
      ST_RUN: begin
        w_busy_nxt = 1'b1;
      end
      ST_PASS: begin
        w_done_nxt = 1'b1;
        w_pass_nxt = 1'b1;
      end
      ST_FAIL, ST_TOUT: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_pass_nxt = 1'b0;
      end
    endcase
  end

  // Registered status flags.
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_pass <= w_pass_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: sequence length, match index, watchdog, Reg_Out history
  // ---------------------------------------------------------------------------
  // Run bookkeeping; match_idx freezes outside RUN and on a strict failure.
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      r_n           <= IDX_ZERO;
      r_match_idx   <= IDX_ZERO;
      r_wdog        <= WD_ZERO;
      r_prev        <= {DataWidth{1'b0}};
      r_first_obs   <= 1'b0;
      r_match_pulse <= 1'b0;
    end else begin
      r_prev        <= Reg_Out;
      r_match_pulse <= w_match;
      if (w_start_take) begin
        r_n         <= w_n_clamped;
        r_match_idx <= IDX_ZERO;
        r_wdog      <= WD_ZERO;
        r_first_obs <= 1'b1;
      end else if (w_in_run) begin
        r_first_obs <= 1'b0;
        if (w_match) begin
          r_match_idx <= r_match_idx + IDX_ONE;
          r_wdog      <= WD_ZERO;
        end else if (w_seq_done) begin
          r_wdog      <= r_wdog;
        end else begin
          // Wrap on the last count is harmless: the FSM leaves RUN then.
          r_wdog      <= r_wdog + WD_ONE;
        end
      end else begin
        r_first_obs <= 1'b0;
      end
    end
  end

`ifdef CHECKER_STRICT_EN
  logic [DataWidth-1:0] r_fail_value;

  // Latch the value that broke the sequence; each fresh start clears it.
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      r_fail_value <= {DataWidth{1'b0}};
    end else if (w_start_take) begin
      r_fail_value <= {DataWidth{1'b0}};
    end else if (w_mismatch && !w_match) begin
      r_fail_value <= Reg_Out;
    end else begin
      r_fail_value <= r_fail_value;
    end
  end

  assign fail_value = r_fail_value;
`else
  assign fail_value = {DataWidth{1'b0}};
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign match_pulse = r_match_pulse;
  assign match_idx   = r_match_idx;

endmodule

// File: tb/tb_brq_result_checker.sv
module tb_brq_result_checker;

  localparam int DW    = 32;
  localparam int DEPTH = 128;
  localparam int TMO   = 16;

`ifdef CHECKER_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PASS = 2;
  localparam int M_FAIL = 3;
  localparam int M_TOUT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          exp_we;
  logic [6:0]    exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [7:0]    exp_count;
  logic          start;
  logic [DW-1:0] reg_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic          match_pulse;
  logic [7:0]    match_idx;
  logic [DW-1:0] fail_value;

  always #5 clk = ~clk;

  brq_result_checker #(
    .DataWidth(DW),
    .DEPTH    (DEPTH),
    .TIMEOUT  (TMO)
  ) dut (
    .brq_clk    (clk),
    .brq_rst    (rst),
    .exp_we     (exp_we),
    .exp_addr   (exp_addr),
    .exp_wdata  (exp_wdata),
    .exp_count  (exp_count),
    .start      (start),
    .Reg_Out    (reg_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .match_pulse(match_pulse),
    .match_idx  (match_idx),
    .fail_value (fail_value)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what the checker should report after each clock edge.
  int            m_st    = M_IDLE;
  int            m_n     = 0;
  int            m_idx   = 0;
  int            m_wd    = 0;
  bit            m_first = 1'b0;
  bit            m_pulse = 1'b0;
  logic [DW-1:0] m_prev  = '0;
  logic [DW-1:0] m_fv    = '0;
  logic [DW-1:0] m_tab [DEPTH];

  typedef struct {
    logic [DW-1:0] reg_out;
    logic          busy;
    logic          done;
    logic          pass;
    logic          pulse;
    logic [7:0]    idx;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Explicit status check against hand-derived values.
  task automatic st(input string name, input bit eb, input bit ed, input bit ep, input int ei);
    chk(name, 64'({busy, done, pass, match_idx}), 64'({eb, ed, ep, 8'(ei)}));
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_tick();
    bit was_run = (m_st == M_RUN);
    bit obs;
    int nst = m_st;
    m_pulse = 1'b0;
    if (rst) begin
      nst     = M_IDLE;
      m_n     = 0;
      m_idx   = 0;
      m_wd    = 0;
      m_fv    = '0;
      m_first = 1'b0;
    end else if (was_run) begin
      if (m_idx == m_n) begin
        nst = M_PASS;
      end else begin
        obs = m_first || (reg_out != m_prev);
        if (obs && (reg_out == m_tab[m_idx])) begin
          m_idx++;
          m_pulse = 1'b1;
          m_wd    = 0;
        end else if (STRICT && obs) begin
          nst  = M_FAIL;
          m_fv = reg_out;
        end else if (m_wd == TMO - 1) begin
          nst = M_TOUT;
        end else begin
          m_wd++;
        end
      end
      m_first = 1'b0;
    end else if (start) begin
      nst     = M_RUN;
      m_n     = (int'(exp_count) > DEPTH) ? DEPTH : int'(exp_count);
      m_idx   = 0;
      m_wd    = 0;
      m_first = 1'b1;
      m_fv    = '0;
    end
    if (exp_we && !was_run) m_tab[exp_addr] = exp_wdata;
    m_prev = rst ? '0 : reg_out;
    m_st   = nst;
  endtask

  // One clock: update model, clock the DUT, compare away from the edge.
  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    chk("model_status",
        64'({busy, done, pass, match_pulse, match_idx}),
        64'({(m_st == M_RUN), (m_st == M_PASS || m_st == M_FAIL || m_st == M_TOUT),
             (m_st == M_PASS), m_pulse, 8'(m_idx)}));
    chk("model_fail_value", 64'(fail_value), 64'(m_fv));
    start  = 1'b0;
    exp_we = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    exp_we    = 1'b1;
    exp_addr  = 7'(a);
    exp_wdata = d;
    step();
  endtask

  task automatic go(input int cnt);
    exp_count = 8'(cnt);
    start     = 1'b1;
    step();
  endtask

  task automatic drv(input logic [DW-1:0] v);
    reg_out = v;
    step();
  endtask

  initial begin
    int pulses;
    int k;
    int n;
    int cnt;
    int sel;

    rst = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    exp_count = '0; start = 1'b0; reg_out = '0;
    for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;

    // Reset state
    step();
    st("reset_status", 1'b0, 1'b0, 1'b0, 0);
    chk("reset_pulse", 64'(match_pulse), 64'(0));
    chk("reset_fail_value", 64'(fail_value), 64'(0));
    rst = 1'b0;

    // Fill the whole table with distinct values
    for (int i = 0; i < DEPTH; i++) wr(i, 32'h1000 + 32'(i) * 32'd7);

    // Basic pass (table-driven)
`ifdef CHECKER_STRICT_EN
    vecs.push_back('{32'd495,  1'b1, 1'b0, 1'b0, 1'b1, 8'd1});
    vecs.push_back('{32'd1168, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2});
    vecs.push_back('{32'd565,  1'b1, 1'b0, 1'b0, 1'b1, 8'd3});
    vecs.push_back('{32'd1176, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4});
    vecs.push_back('{32'd1176, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4});
    vecs.push_back('{32'd1176, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4});
`else
    vecs.push_back('{32'd0,    1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{32'd495,  1'b1, 1'b0, 1'b0, 1'b1, 8'd1});
    vecs.push_back('{32'd7,    1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{32'd1168, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2});
    vecs.push_back('{32'd565,  1'b1, 1'b0, 1'b0, 1'b1, 8'd3});
    vecs.push_back('{32'd1176, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4});
    vecs.push_back('{32'd1176, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4});
    vecs.push_back('{32'd1176, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4});
`endif
    wr(0, 32'd495); wr(1, 32'd1168); wr(2, 32'd565); wr(3, 32'd1176);
    reg_out = '0;
    go(4);
    st("basic_start", 1'b1, 1'b0, 1'b0, 0);
    pulses = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      drv(vecs[i].reg_out);
      if (match_pulse) pulses++;
      chk($sformatf("basic_vec%0d", i),
          64'({busy, done, pass, match_pulse, match_idx}),
          64'({vecs[i].busy, vecs[i].done, vecs[i].pass, vecs[i].pulse, vecs[i].idx}));
    end
    chk("basic_pulses", 64'(pulses), 64'(4));

    // Held value against duplicate entries: one match, then timeout
    wr(0, 32'd922); wr(1, 32'd922);
    reg_out = 32'd922;
    go(2);
    pulses = 0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      drv(32'd922);
      k++;
      if (match_pulse) pulses++;
    end
    chk("held_pulses", 64'(pulses), 64'(1));
    st("held_run", 1'b1, 1'b0, 1'b0, 1);
    while (!done && k < 40) begin
      drv(32'd922);
      k++;
    end
    chk("held_tout_cycle", 64'(k), 64'(17));
    st("held_tout", 1'b0, 1'b1, 1'b0, 1);
    // 922, 0, 922 matches both entries (strict builds fail on the 0)
    go(2);
    drv(32'd922); drv(32'd0); drv(32'd922); drv(32'd922);
    st("dup_pass", 1'b0, 1'b1, !STRICT, STRICT ? 1 : 2);

    // Timeout with Reg_Out stuck at 0
    wr(0, 32'd5);
    reg_out = '0;
    go(1);
    k = 0;
    while (!done && k < 40) begin
      drv(32'd0);
      k++;
    end
    chk("tout_cycle", 64'(k), 64'(STRICT ? 1 : 16));
    st("tout_status", 1'b0, 1'b1, 1'b0, 0);

    // Mismatch after a partial match
    wr(0, 32'd495); wr(1, 32'd1168);
    reg_out = 32'd495;
    go(2);
    drv(32'd495); drv(32'd1000); drv(32'd1000);
    st("mismatch_state", !STRICT, STRICT, 1'b0, 1);
    chk("mismatch_fail_value", 64'(fail_value), 64'(STRICT ? 1000 : 0));
    drv(32'd1168); drv(32'd1168);
    st("mismatch_after", 1'b0, 1'b1, !STRICT, STRICT ? 1 : 2);

    // Empty sequence
    go(0);
    st("empty_run", 1'b1, 1'b0, 1'b0, 0);
    step();
    st("empty_pass", 1'b0, 1'b1, 1'b1, 0);

    // exp_count above DEPTH clamps to DEPTH
    go(200);
    for (int i = 0; i < DEPTH; i++) drv(m_tab[i]);
    st("clamp_full", 1'b1, 1'b0, 1'b0, 128);
    step();
    st("clamp_pass", 1'b0, 1'b1, 1'b1, 128);

    // exp_we during RUN is ignored
    go(2);
    exp_we = 1'b1; exp_addr = 7'd1; exp_wdata = 32'd999;
    drv(32'd495);
    drv(32'd1168);
    st("we_in_run", 1'b1, 1'b0, 1'b0, 2);
    step();
    st("we_in_run_pass", 1'b0, 1'b1, 1'b1, 2);

    // Write and start in the same idle cycle
    exp_we = 1'b1; exp_addr = 7'd0; exp_wdata = 32'd4242;
    reg_out = '0;
    go(1);
    drv(32'd4242);
    st("wr_start_same", 1'b1, 1'b0, 1'b0, 1);
    step();
    st("wr_start_pass", 1'b0, 1'b1, 1'b1, 1);

    // Reset mid-run, then restart on the same table
    wr(0, 32'd495);
    go(4);
    drv(32'd495); drv(32'd1168);
    st("pre_reset", 1'b1, 1'b0, 1'b0, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    st("mid_reset", 1'b0, 1'b0, 1'b0, 0);
    chk("mid_reset_pulse", 64'(match_pulse), 64'(0));
    chk("mid_reset_fail_value", 64'(fail_value), 64'(0));
    reg_out = '0;
    go(4);
    drv(32'd495); drv(32'd1168); drv(32'd565); drv(32'd1176);
    step();
    st("restart_pass", 1'b0, 1'b1, 1'b1, 4);

    // Randomized runs against the model
    for (int r = 0; r < 60; r++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) wr(i, 32'($urandom_range(0, 7)));
      cnt = n + (($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 0);
      reg_out = 32'($urandom_range(0, 7));
      go(cnt);
      for (int c = 0; c < 40 && m_st == M_RUN; c++) begin
        sel = $urandom_range(0, 9);
        if (sel <= 4) begin
          reg_out = m_tab[m_idx];
        end else if (sel <= 6) begin
          reg_out = reg_out;
        end else if (sel <= 8) begin
          reg_out = 32'($urandom_range(0, 7));
        end else begin
          exp_we    = 1'b1;
          exp_addr  = 7'($urandom_range(0, 7));
          exp_wdata = 32'($urandom_range(0, 7));
          start     = 1'b1;
          exp_count = 8'($urandom_range(0, 8));
        end
        if ($urandom_range(0, 49) == 0) rst = 1'b1;
        step();
        rst = 1'b0;
      end
      if (m_st == M_RUN) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
